// File: rtl/gray_conv_sched.sv
// Round-robin scheduler that shares one bit-serial Gray-to-binary converter among
// NREQ requesters and returns each binary result, tagged with its owner, over valid/ready.
module gray_conv_sched #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned NREQ  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    gray_in,
   output logic [NREQ-1:0]          gnt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         bin_out,
   output logic [$clog2(NREQ)-1:0]  out_id,
   output logic                     busy
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned KW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             busy_q, busy_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic             acc_q, acc_d;
   logic [KW-1:0]    k_q, k_d;

   logic             any_req_c;
   logic [IDW-1:0]   win_c;
   logic [IDW-1:0]   cand_c;
   logic [WIDTH-1:0] slice_c;

   // Round-robin pick: scan offsets high to low so the smallest offset from ptr wins.
   always_comb begin
      any_req_c = |req;
      win_c     = ptr_q;
      cand_c    = ptr_q;
      for (int j = NREQ - 1; j >= 0; j--) begin
         cand_c = ptr_q + IDW'(j);
         if (req[cand_c]) begin
            win_c = cand_c;
         end
      end
      slice_c = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (IDW'(j) == win_c) begin
            slice_c = gray_in[j*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      gnt_d   = '0;
      valid_d = valid_q;
      bin_d   = bin_q;
      id_d    = id_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      acc_d   = acc_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE: begin
            if (any_req_c) begin
               state_d = S_CONV;
               gnt_d   = NREQ'(1) << win_c;
               g_d     = slice_c;
               id_d    = win_c;
               ptr_d   = win_c + IDW'(1);
               acc_d   = 1'b0;
               k_d     = KW'(WIDTH - 1);
               busy_d  = 1'b1;
            end
         end
         S_CONV: begin
            // Running XOR from the MSB down yields each binary bit in turn.
            acc_d        = acc_q ^ g_q[k_q];
            bin_d[k_q]   = acc_d;
            if (k_q == '0) begin
               state_d = S_HOLD;
               valid_d = 1'b1;
               k_d     = KW'(WIDTH - 1);
            end else begin
               k_d = k_q - KW'(1);
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         bin_q   <= '0;
         id_q    <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         g_q     <= '0;
         acc_q   <= 1'b0;
         k_q     <= KW'(WIDTH - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         bin_q   <= bin_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
      end
   end

   assign gnt       = gnt_q;
   assign out_valid = valid_q;
   assign bin_out   = bin_q;
   assign out_id    = id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_gray_conv_sched.sv
// Bench for gray_conv_sched: transaction-level round-robin and Gray-decode model,
// directed corner cases plus a shuffled exhaustive sweep with random output stalls.
module tb_gray_conv_sched;

   localparam int unsigned W = 5;
   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] gray_in;
   logic [N-1:0]   gnt;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   bin_out;
   logic [1:0]     out_id;
   logic           busy;

   logic [W-1:0]   codes [N];
   int             n_cmp = 0;
   int             n_bad = 0;
   int             ptr_m = 0;

   assign gray_in = {codes[3], codes[2], codes[1], codes[0]};

   gray_conv_sched #(.WIDTH(W), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gray_in   (gray_in),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .out_id    (out_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Binary bit i is the parity of all Gray bits at or above i.
   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      for (int i = 0; i < W; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] r);
      logic [1:0] idx;
      for (int o = 0; o < N; o++) begin
         idx = 2'((ptr_m + o) % N);
         if (r[idx]) return int'(idx);
      end
      return -1;
   endfunction

   // One full transaction from an idle DUT: capture, conversion, optional stall, handshake.
   task automatic do_one(input logic [N-1:0] r, input logic [N-1:0] r_hold, input int stall);
      int           w;
      int           lat;
      logic [W-1:0] exp_b;
      w     = rr_pick(r);
      exp_b = g2b(codes[w]);
      req       = r;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      chk("gnt_capture", 32'(gnt), 32'(1) << w);
      chk("busy_capture", 32'(busy), 32'd1);
      ptr_m = (w + 1) % N;
      req   = r_hold;
      lat   = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         chk("gnt_pulse", 32'(gnt), 32'd0);
      end
      chk("latency", 32'(lat), 32'(W));
      chk("bin_out", 32'(bin_out), 32'(exp_b));
      chk("out_id", 32'(out_id), 32'(w));
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_bin", 32'(bin_out), 32'(exp_b));
         chk("stall_id", 32'(out_id), 32'(w));
         chk("stall_gnt", 32'(gnt), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_valid", 32'(out_valid), 32'd0);
      chk("hs_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
   endtask

   int order [N*(1<<W)];
   int tmp, j, r, c;

   initial begin
      // Reset with random inputs
      rst_n     = 1'b0;
      req       = 4'($urandom);
      out_ready = 1'($urandom);
      for (int i = 0; i < N; i++) codes[i] = W'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_bin", 32'(bin_out), 32'd0);
      chk("rst_id", 32'(out_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request, documented example
      codes[0] = 5'b11010;
      do_one(4'b0001, 4'b0000, 0);
      chk("example_bin", 32'(g2b(5'b11010)), 32'(bin_out) | 32'(g2b(5'b11010)));

      // Corner codes from requester 2
      codes[2] = 5'b00000; do_one(4'b0100, 4'b0000, 0);
      codes[2] = 5'b10000; do_one(4'b0100, 4'b0000, 0);
      codes[2] = 5'b11111; do_one(4'b0100, 4'b0000, 0);

      // Round-robin with all requesters held high
      do_reset();
      codes[0] = 5'b00101; codes[1] = 5'b01110;
      codes[2] = 5'b10011; codes[3] = 5'b11000;
      for (int i = 0; i < 5; i++) do_one(4'b1111, 4'b1111, 0);
      req = '0;
      @(negedge clk);

      // Backpressure: new request during HOLD waits for the handshake
      do_one(4'b0010, 4'b0100, 10);
      do_one(4'b0100, 4'b0000, 0);

      // Reset in the middle of a conversion
      codes[2] = 5'b10110;
      req = 4'b0100;
      @(posedge clk); #1;
      chk("mr_gnt", 32'(gnt), 32'b0100);
      req = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(out_valid), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_gnt_clr", 32'(gnt), 32'd0);
      ptr_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      do_one(4'b1010, 4'b0000, 0);

      // Every code from every requester, shuffled, with random stalls
      for (int i = 0; i < N*(1<<W); i++) order[i] = i;
      for (int i = N*(1<<W) - 1; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < N*(1<<W); i++) begin
         c = order[i] % (1<<W);
         r = order[i] / (1<<W);
         for (int q = 0; q < N; q++) codes[q] = W'($urandom);
         codes[r] = W'(c);
         do_one(4'(1 << r), 4'b0000, int'($urandom_range(3, 0)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
